// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small LEGv8-style datapath.
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   opcode[10:0]         - instruction[31:21] from the instruction register
//   alu_zero             - ALU zero flag, consulted in BRANCH for CBZ
//   imem_ready           - completes the instruction-fetch handshake
//   dmem_ready           - completes a data-memory access
//   imem_req             - instruction fetch request
//   dmem_req, dmem_we    - data request / write enable (STUR)
//   ir_write, pc_write   - load IR / load PC
//   pc_src[1:0]          - 00 = PC+4, 01 = branch target
//   reg_write, mem_to_reg, reg2loc - register-file controls
//   alu_src_b[1:0]       - 00 = register, 01 = extended immediate
//   alu_op[1:0]          - 00 = add, 01 = pass/zero-test, 10 = R-type decode
//   imm_sel[1:0]         - 00 = B, 10 = CB, 11 = D immediate format
//   state[3:0]           - current state code (debug)
//   retired[COUNT_W-1:0] - completed-instruction counter, wraps silently
//   illegal              - sticky unsupported-opcode flag
module multicycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        opcode,
  input  logic               alu_zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg2loc,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_sel,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LD_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  state_t cur, nxt;
  logic   retire;
  logic   set_illegal;

  logic is_ldur, is_stur, is_mem, is_r, is_cbz, is_b;

  assign is_ldur = (opcode == 11'b11111000010);
  assign is_stur = (opcode == 11'b11111000000);
  assign is_mem  = is_ldur | is_stur;
  assign is_r    = (opcode == 11'b10001011000) | (opcode == 11'b11001011000) |
                   (opcode == 11'b10001010000) | (opcode == 11'b10101010000);
  assign is_cbz  = (opcode[10:3] == 8'b10110100);
  assign is_b    = (opcode[10:5] == 6'b000101);

  assign state = cur;

  // The IR only loads in FETCH, so opcode stays valid for the whole
  // instruction; MEM_ADDR and BRANCH re-decode it instead of keeping a copy.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg2loc     = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    imm_sel     = 2'b00;
    retire      = 1'b0;
    set_illegal = 1'b0;
    nxt         = cur;

    if (reset) begin
      // Idle FETCH outputs; imem_ready cannot complete a fetch under reset.
      imem_req = 1'b1;
      nxt      = S_FETCH;
    end else begin
      unique case (cur)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
            nxt      = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_mem)      imm_sel = 2'b11;
          else if (is_cbz) imm_sel = 2'b10;
          else             imm_sel = 2'b00;
          if (is_mem)               nxt = S_MEM_ADDR;
          else if (is_r)            nxt = S_R_EXEC;
          else if (is_cbz || is_b)  nxt = S_BRANCH;
          else begin
            set_illegal = 1'b1;
            retire      = 1'b1;
            nxt         = S_FETCH;
          end
        end
        S_MEM_ADDR: begin
          alu_src_b = 2'b01;
          alu_op    = 2'b00;
          imm_sel   = 2'b11;
          nxt       = is_stur ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          dmem_req = 1'b1;
          if (dmem_ready) nxt = S_LD_WB;
        end
        S_LD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
          reg2loc  = 1'b1;
          if (dmem_ready) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
          nxt       = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          nxt       = S_FETCH;
        end
        S_BRANCH: begin
          pc_src = 2'b01;
          retire = 1'b1;
          nxt    = S_FETCH;
          if (is_cbz) begin
            reg2loc  = 1'b1;
            alu_op   = 2'b01;
            imm_sel  = 2'b10;
            pc_write = alu_zero;
          end else begin
            imm_sel  = 2'b00;
            pc_write = 1'b1;
          end
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire)      retired <= retired + COUNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111010;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic        clk, reset;
  logic [10:0] opcode;
  logic        alu_zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write, mem_to_reg, reg2loc;
  logic [1:0]  alu_src_b, alu_op, imm_sel;
  logic [3:0]  state;
  logic [3:0]  retired;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_ret;

  multicycle_control #(.COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .state(state), .retired(retired), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ready = 1'b1; opcode = OP_ADD;
    step();
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%0b exp=0", illegal); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_imem_req got=%0b exp=1", imem_req); end
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL reset_ir_write got=%0b exp=0", ir_write); end
    n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL reset_pc_write got=%0b exp=0", pc_write); end
    step();
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_hold_state got=%0d exp=0", state); end
    reset = 1'b0; imem_ready = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_idle_req got=%0b exp=1", imem_req); end
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_ir got=%0b exp=0", ir_write); end
    step();
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL fetch_wait_state got=%0d exp=0", state); end
    exp_ret = 4'd0;
  endtask

  task automatic test_add;
    opcode = OP_ADD; imem_ready = 1'b1;
    #1;
    n_checks++; if (ir_write !== 1'b1) begin n_fail++; $display("FAIL add_fetch_ir got=%0b exp=1", ir_write); end
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL add_fetch_pcw got=%0b exp=1", pc_write); end
    n_checks++; if (pc_src !== 2'b00) begin n_fail++; $display("FAIL add_fetch_pcsrc got=%0b exp=00", pc_src); end
    step();
    // imem_ready left high: must be ignored outside FETCH
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL add_decode_state got=%0d exp=1", state); end
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL add_decode_ir got=%0b exp=0", ir_write); end
    n_checks++; if (imm_sel !== 2'b00) begin n_fail++; $display("FAIL add_decode_imm got=%0b exp=00", imm_sel); end
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL add_decode_rw got=%0b exp=0", reg_write); end
    step();
    n_checks++; if (state !== 4'd6) begin n_fail++; $display("FAIL add_exec_state got=%0d exp=6", state); end
    n_checks++; if (alu_op !== 2'b10) begin n_fail++; $display("FAIL add_exec_aluop got=%0b exp=10", alu_op); end
    n_checks++; if (alu_src_b !== 2'b00) begin n_fail++; $display("FAIL add_exec_srcb got=%0b exp=00", alu_src_b); end
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL add_exec_rw got=%0b exp=0", reg_write); end
    step();
    n_checks++; if (state !== 4'd7) begin n_fail++; $display("FAIL add_wb_state got=%0d exp=7", state); end
    n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL add_wb_rw got=%0b exp=1", reg_write); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL add_wb_retired got=%0d exp=%0d", retired, exp_ret); end
    imem_ready = 1'b0;
    step();
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL add_done_state got=%0d exp=0", state); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL add_done_retired got=%0d exp=%0d", retired, exp_ret); end
    n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL add_done_rw got=%0b exp=0", reg_write); end
  endtask

  task automatic test_ldur_wait;
    int cnt;
    cnt = 0;
    opcode = OP_LDUR; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL ld_decode_state got=%0d exp=1", state); end
    n_checks++; if (imm_sel !== 2'b11) begin n_fail++; $display("FAIL ld_decode_imm got=%0b exp=11", imm_sel); end
    dmem_ready = 1'b1;
    step();
    n_checks++; if (state !== 4'd2) begin n_fail++; $display("FAIL ld_addr_state got=%0d exp=2", state); end
    n_checks++; if (alu_src_b !== 2'b01) begin n_fail++; $display("FAIL ld_addr_srcb got=%0b exp=01", alu_src_b); end
    n_checks++; if (imm_sel !== 2'b11) begin n_fail++; $display("FAIL ld_addr_imm got=%0b exp=11", imm_sel); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_addr_dreq got=%0b exp=0", dmem_req); end
    dmem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (state !== 4'd3) begin n_fail++; $display("FAIL ld_rd_state[%0d] got=%0d exp=3", i, state); end
      n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_rd_we[%0d] got=%0b exp=0", i, dmem_we); end
      if (dmem_req === 1'b1) cnt++;
      if (i == 2) dmem_ready = 1'b1;
      step();
    end
    dmem_ready = 1'b0;
    #1;
    n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL ld_dreq_cycles got=%0d exp=3", cnt); end
    n_checks++; if (state !== 4'd4) begin n_fail++; $display("FAIL ld_wb_state got=%0d exp=4", state); end
    n_checks++; if (mem_to_reg !== 1'b1) begin n_fail++; $display("FAIL ld_wb_m2r got=%0b exp=1", mem_to_reg); end
    n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL ld_wb_rw got=%0b exp=1", reg_write); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_wb_dreq got=%0b exp=0", dmem_req); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL ld_done_state got=%0d exp=0", state); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ld_done_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_cbz;
    for (int p = 0; p < 2; p++) begin
      opcode = OP_CBZ; imem_ready = 1'b1;
      step();
      imem_ready = 1'b0; alu_zero = 1'b1;
      #1;
      n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL cbz%0d_decode_state got=%0d exp=1", p, state); end
      n_checks++; if (imm_sel !== 2'b10) begin n_fail++; $display("FAIL cbz%0d_decode_imm got=%0b exp=10", p, imm_sel); end
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL cbz%0d_decode_pcw got=%0b exp=0", p, pc_write); end
      step();
      alu_zero = (p == 1);
      #1;
      n_checks++; if (state !== 4'd8) begin n_fail++; $display("FAIL cbz%0d_br_state got=%0d exp=8", p, state); end
      n_checks++; if (pc_write !== (p == 1)) begin n_fail++; $display("FAIL cbz%0d_br_pcw got=%0b exp=%0d", p, pc_write, p); end
      n_checks++; if (pc_src !== 2'b01) begin n_fail++; $display("FAIL cbz%0d_br_pcsrc got=%0b exp=01", p, pc_src); end
      n_checks++; if (imm_sel !== 2'b10) begin n_fail++; $display("FAIL cbz%0d_br_imm got=%0b exp=10", p, imm_sel); end
      n_checks++; if (reg2loc !== 1'b1) begin n_fail++; $display("FAIL cbz%0d_br_r2l got=%0b exp=1", p, reg2loc); end
      n_checks++; if (alu_op !== 2'b01) begin n_fail++; $display("FAIL cbz%0d_br_aluop got=%0b exp=01", p, alu_op); end
      step();
      alu_zero = 1'b0;
      exp_ret = exp_ret + 4'd1;
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL cbz%0d_done_state got=%0d exp=0", p, state); end
      n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL cbz%0d_done_retired got=%0d exp=%0d", p, retired, exp_ret); end
    end
  endtask

  task automatic test_b;
    opcode = OP_B; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; alu_zero = 1'b0;
    #1;
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL b_decode_state got=%0d exp=1", state); end
    n_checks++; if (imm_sel !== 2'b00) begin n_fail++; $display("FAIL b_decode_imm got=%0b exp=00", imm_sel); end
    step();
    n_checks++; if (state !== 4'd8) begin n_fail++; $display("FAIL b_br_state got=%0d exp=8", state); end
    n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL b_br_pcw got=%0b exp=1", pc_write); end
    n_checks++; if (pc_src !== 2'b01) begin n_fail++; $display("FAIL b_br_pcsrc got=%0b exp=01", pc_src); end
    n_checks++; if (reg2loc !== 1'b0) begin n_fail++; $display("FAIL b_br_r2l got=%0b exp=0", reg2loc); end
    n_checks++; if (alu_op !== 2'b00) begin n_fail++; $display("FAIL b_br_aluop got=%0b exp=00", alu_op); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL b_done_state got=%0d exp=0", state); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL b_done_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_stur;
    opcode = OP_STUR; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    n_checks++; if (imm_sel !== 2'b11) begin n_fail++; $display("FAIL st_decode_imm got=%0b exp=11", imm_sel); end
    step();
    n_checks++; if (state !== 4'd2) begin n_fail++; $display("FAIL st_addr_state got=%0d exp=2", state); end
    step();
    n_checks++; if (state !== 4'd5) begin n_fail++; $display("FAIL st_wr_state got=%0d exp=5", state); end
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_wr_dreq got=%0b exp=1", dmem_req); end
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL st_wr_we got=%0b exp=1", dmem_we); end
    n_checks++; if (reg2loc !== 1'b1) begin n_fail++; $display("FAIL st_wr_r2l got=%0b exp=1", reg2loc); end
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL st_done_state got=%0d exp=0", state); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL st_done_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_illegal;
    opcode = OP_BAD; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL ill_decode_state got=%0d exp=1", state); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_decode_flag got=%0b exp=0", illegal); end
    step();
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL ill_done_state got=%0d exp=0", state); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag_set got=%0b exp=1", illegal); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ill_retired got=%0d exp=%0d", retired, exp_ret); end
    opcode = OP_ADD; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step(); step(); step();
    exp_ret = exp_ret + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL ill_add_state got=%0d exp=0", state); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag_sticky got=%0b exp=1", illegal); end
    n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ill_add_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid_write;
    opcode = OP_STUR; imem_ready = 1'b1; dmem_ready = 1'b0;
    step();
    imem_ready = 1'b0;
    step(); step(); step();
    n_checks++; if (state !== 4'd5) begin n_fail++; $display("FAIL rst_mw_wait_state got=%0d exp=5", state); end
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mw_wait_dreq got=%0b exp=1", dmem_req); end
    reset = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mw_hi_dreq got=%0b exp=0", dmem_req); end
    n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mw_hi_we got=%0b exp=0", dmem_we); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mw_hi_ireq got=%0b exp=1", imem_req); end
    step();
    reset = 1'b0;
    #1;
    exp_ret = 4'd0;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rst_mw_state got=%0d exp=0", state); end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL rst_mw_retired got=%0d exp=0", retired); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_mw_illegal got=%0b exp=0", illegal); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mw_dreq got=%0b exp=0", dmem_req); end
  endtask

  task automatic run_b;
    opcode = OP_B; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step(); step();
  endtask

  task automatic test_wrap;
    for (int k = 1; k <= 16; k++) begin
      run_b();
      exp_ret = exp_ret + 4'd1;
      n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL wrap_retired[%0d] got=%0d exp=%0d", k, retired, exp_ret); end
    end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL wrap_final got=%0d exp=0", retired); end
  endtask

  initial begin
    reset = 1'b1; opcode = '0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; exp_ret = '0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_b();
    test_stur();
    test_illegal();
    test_reset_mid_write();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
